// File: rtl/fifo_ptr_pkg.sv
// Shared helpers for async-FIFO pointer blocks: Gray/binary conversion on up to 17-bit pointers.
package fifo_ptr_pkg;

   localparam int unsigned DEFAULT_ADDR_W = 4;
   localparam int unsigned MAX_PTR_W      = 17;

   typedef logic [MAX_PTR_W-1:0] ptr_t;

   // Low w bits set; w == MAX_PTR_W wraps to all ones.
   function automatic ptr_t ptr_mask(input int unsigned w);
      return (ptr_t'(1) << w) - ptr_t'(1);
   endfunction

   function automatic ptr_t bin2gray(input ptr_t b, input int unsigned w);
      ptr_t v;
      v = b & ptr_mask(w);
      return v ^ (v >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g, input int unsigned w);
      ptr_t v;
      ptr_t r;
      v = g & ptr_mask(w);
      r = v;
      for (int i = 1; i < MAX_PTR_W; i++) begin
         r = r ^ (v >> i);
      end
      return r;
   endfunction

endpackage

// File: rtl/ptr_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module ptr_gray2bin #(
   parameter int unsigned WIDTH = 5
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   logic acc;

   always_comb begin
      acc = 1'b0;
      bin = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         acc    = acc ^ gray[i];
         bin[i] = acc;
      end
   end

endmodule

// File: rtl/fifo_wptr_full.sv
// Async-FIFO write pointer, Gray pointer output, and full / almost-full / level flags.
// Optional macro WPTR_SYNC_EN adds a 2-flop synchronizer on rptr_gray_in.
module fifo_wptr_full
   import fifo_ptr_pkg::*;
#(
   parameter int unsigned  ADDR_W    = DEFAULT_ADDR_W,
   parameter int unsigned  AF_THRESH = 12,
   localparam int unsigned PTR_W     = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              winc,
   input  logic [PTR_W-1:0]  rptr_gray_in,
   output logic [ADDR_W-1:0] waddr,
   output logic [PTR_W-1:0]  wptr_gray,
   output logic              wen,
   output logic              wfull,
   output logic              wafull,
   output logic [PTR_W-1:0]  wlevel
);

   localparam logic [PTR_W-1:0] AfLevel = PTR_W'(AF_THRESH);

   logic [PTR_W-1:0] wbin_q, wbin_d;
   logic [PTR_W-1:0] wgray_q, wgray_d;
   logic [PTR_W-1:0] wlevel_q, wlevel_d;
   logic             wfull_q, wfull_d;
   logic             wafull_q, wafull_d;
   logic [PTR_W-1:0] rq;
   logic [PTR_W-1:0] rbin;

`ifdef WPTR_SYNC_EN
   logic [PTR_W-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= rptr_gray_in;
         sync2_q <= sync1_q;
      end
   end

   assign rq = sync2_q;
`else
   assign rq = rptr_gray_in;
`endif

   ptr_gray2bin #(
      .WIDTH (PTR_W)
   ) u_rq_gray2bin (
      .gray (rq),
      .bin  (rbin)
   );

   assign wen = winc & ~wfull_q;

   always_comb begin
      wbin_d   = wbin_q + PTR_W'(wen);
      wgray_d  = PTR_W'(bin2gray(ptr_t'(wbin_d), PTR_W));
      // Full when the write pointer is exactly one lap ahead of the read pointer.
      wfull_d  = (wgray_d == {~rq[PTR_W-1:PTR_W-2], rq[PTR_W-3:0]});
      wlevel_d = wbin_d - rbin;
      wafull_d = (wlevel_d >= AfLevel);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin_q   <= '0;
         wgray_q  <= '0;
         wfull_q  <= 1'b0;
         wafull_q <= 1'b0;
         wlevel_q <= '0;
      end else begin
         wbin_q   <= wbin_d;
         wgray_q  <= wgray_d;
         wfull_q  <= wfull_d;
         wafull_q <= wafull_d;
         wlevel_q <= wlevel_d;
      end
   end

   assign waddr     = wbin_q[ADDR_W-1:0];
   assign wptr_gray = wgray_q;
   assign wfull     = wfull_q;
   assign wafull    = wafull_q;
   assign wlevel    = wlevel_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Randomized bench for fifo_wptr_full against a counter-based occupancy model.
// Honours WPTR_SYNC_EN by delaying the model's view of the read pointer by two edges.
module tb_fifo_wptr_full;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam int unsigned AF     = 12;

   logic              clk;
   logic              rst_n;
   logic              winc;
   logic [PTR_W-1:0]  rptr_gray_in;
   logic [ADDR_W-1:0] waddr;
   logic [PTR_W-1:0]  wptr_gray;
   logic              wen;
   logic              wfull;
   logic              wafull;
   logic [PTR_W-1:0]  wlevel;

   fifo_wptr_full #(
      .ADDR_W    (ADDR_W),
      .AF_THRESH (AF)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .winc         (winc),
      .rptr_gray_in (rptr_gray_in),
      .waddr        (waddr),
      .wptr_gray    (wptr_gray),
      .wen          (wen),
      .wfull        (wfull),
      .wafull       (wafull),
      .wlevel       (wlevel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // Model state: total writes accepted and total reads seen, as plain counters.
   int m_wtot = 0;
   int m_rtot = 0;
   int m_s1   = 0;
   int m_s2   = 0;
   int m_level = 0;
   bit m_full = 0;
   bit m_af   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [PTR_W-1:0] to_gray(input int n);
      int b;
      b = n % (2 * DEPTH);
      return PTR_W'(b ^ (b >> 1));
   endfunction

   task automatic model_reset();
      m_wtot = 0; m_rtot = 0; m_s1 = 0; m_s2 = 0;
      m_level = 0; m_full = 0; m_af = 0;
   endtask

   // One clock: drive at negedge, check wen/waddr before the edge, registered outputs after.
   task automatic step(input bit w, input bit radv);
      bit exp_wen;
      int rq_tot;
      logic [PTR_W-1:0] prev_gray;
      @(negedge clk);
      winc = w;
      if (radv && m_rtot < m_wtot) m_rtot++;
      rptr_gray_in = to_gray(m_rtot);
      #1;
      exp_wen = w && !m_full;
      check("wen", 32'(wen), 32'(exp_wen));
      check("waddr", 32'(waddr), 32'(m_wtot % DEPTH));
      prev_gray = wptr_gray;
      @(posedge clk);
      if (exp_wen) m_wtot++;
`ifdef WPTR_SYNC_EN
      rq_tot = m_s2;
      m_s2 = m_s1;
      m_s1 = m_rtot;
`else
      rq_tot = m_rtot;
`endif
      m_level = (m_wtot - rq_tot) % (2 * DEPTH);
      m_full  = (m_level == DEPTH);
      m_af    = (m_level >= AF);
      #1;
      check("wptr_gray", 32'(wptr_gray), 32'(to_gray(m_wtot)));
      check("gray_hamming", $countones(wptr_gray ^ prev_gray), 32'(exp_wen));
      check("wfull", 32'(wfull), 32'(m_full));
      check("wafull", 32'(wafull), 32'(m_af));
      check("wlevel", 32'(wlevel), 32'(m_level));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_waddr"}, 32'(waddr), 32'd0);
      check({tag, "_wptr_gray"}, 32'(wptr_gray), 32'd0);
      check({tag, "_wfull"}, 32'(wfull), 32'd0);
      check({tag, "_wafull"}, 32'(wafull), 32'd0);
      check({tag, "_wlevel"}, 32'(wlevel), 32'd0);
   endtask

   initial begin
      rst_n = 1'b1;
      winc = 1'b0;
      rptr_gray_in = '0;
      #2 rst_n = 1'b0;
      #1 check_zero("reset");
      check("reset_wen", 32'(wen), 32'(winc));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Fill with no reads: 16 accepted, 17th dropped.
      for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 1'b0);
      // One read; flags follow after the read pointer propagates.
      step(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

      // Drain to level 8, then simultaneous write and read.
      for (int i = 0; i < 40 && (m_wtot - m_rtot) > 8; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1);

      // Pointer wrap with the reader trailing by two.
      for (int i = 0; i < 40 && (m_wtot - m_rtot) > 2; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45));
      end

      // Asynchronous reset in the middle of a burst.
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("midreset");
      winc = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rptr_gray_in = '0;
      rst_n = 1'b1;
      model_reset();
      #1 check("release_wptr_gray", 32'(wptr_gray), 32'd0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
